// File: rtl/sound_pkg.sv
// Shared constants for the sound core register bus and the serial write bridge.
// Holds field widths, generator register map and bridge FSM state encodings.
package sound_pkg;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 5;
  localparam int FRAME_W = ADDR_W + DATA_W;
  // One extra count value beyond FRAME_W marks an overlong frame.
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [ADDR_W-1:0] PERIOD_A = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PERIOD_B = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] VOL_A    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] VOL_B    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] VOL_N    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ENABLES  = ADDR_W'(5);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/reg_write_bridge_if.sv
// Pin side (three async serial pins) and register-bus side of the write bridge.
// The bridge takes the master view; the pin driver / bus consumer takes the slave view.
interface reg_write_bridge_if;
  import sound_pkg::*;

  logic              cs_n_in;
  logic              sclk_in;
  logic              sdi_in;
  logic              write_strobe;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              frame_err;
  logic [7:0]        frame_count;

  modport master (
    input  cs_n_in, sclk_in, sdi_in,
    output write_strobe, address, data, frame_err, frame_count
  );

  modport slave (
    output cs_n_in, sclk_in, sdi_in,
    input  write_strobe, address, data, frame_err, frame_count
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one async pin with single-cycle rise/fall pulses.
// STAGES must be at least 2; rst_val sets the level the chain assumes during reset.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{rst_val}};
      prev  <= rst_val;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/reg_write_bridge.sv
// Serial-to-register-bus initiator: an 8-bit cs_n/sclk/sdi frame becomes one
// single-cycle register write (3-bit address then 5-bit data, MSB first).
module reg_write_bridge
  import sound_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  reg_write_bridge_if.master  bus
);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  // cs_n chain resets to the asserted level so a frame already running at reset release is ignored.
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .rst_val(1'b0), .pin(bus.cs_n_in),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .rst_val(1'b0), .pin(bus.sclk_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sdi_sync (
    .clk(clk), .rst(rst), .rst_val(1'b0), .pin(bus.sdi_in),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, cs_level, sclk_level, sclk_fall, sdi_rise, sdi_fall};

  state_t             state;
  logic [FRAME_W-1:0] shift;
  logic [CNT_W-1:0]   count;
  logic               strobe_q;
  logic               err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [7:0]         frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      shift         <= '0;
      count         <= '0;
      strobe_q      <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      frame_count_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state <= ST_SHIFT;
            shift <= '0;
            count <= '0;
          end
        end
        ST_SHIFT: begin
          // A cs_n rise wins over a coincident sclk edge: the frame is judged on the prior count.
          if (cs_rise) begin
            if (count == CNT_W'(FRAME_W)) begin
              state         <= ST_COMMIT;
              strobe_q      <= 1'b1;
              addr_q        <= shift[FRAME_W-1:DATA_W];
              data_q        <= shift[DATA_W-1:0];
              frame_count_q <= frame_count_q + 8'd1;
            end else begin
              state <= ST_IDLE;
              err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift <= {shift[FRAME_W-2:0], sdi_level};
            if (count != CNT_W'(FRAME_W + 1)) count <= count + CNT_W'(1);
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.write_strobe = strobe_q;
  assign bus.address      = addr_q;
  assign bus.data         = data_q;
  assign bus.frame_err    = err_q;
  assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_reg_write_bridge.sv
// Directed-plus-random bench for reg_write_bridge: drives pin-level frames and
// compares bus writes against a frame-level model (8 bits in -> one write, else error).
module tb_reg_write_bridge;
  import sound_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [7:0]        c;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   err_seen = 0;
  int   exp_err = 0;
  int   overlap = 0;
  int   strobe_total = 0;
  int   strobe_cyc = 0;
  int   rise_cyc = 0;
  int   model_count = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;

  reg_write_bridge_if bus ();

  reg_write_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.write_strobe) begin
        obs_q.push_back('{a: bus.address, d: bus.data, c: bus.frame_count});
        strobe_cyc = cyc;
        strobe_total++;
      end
      if (bus.frame_err) err_seen++;
      if (bus.write_strobe && bus.frame_err) overlap++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.sdi_in = b;
    hold(4);
    bus.sclk_in = 1'b1;
    hold(4);
    bus.sclk_in = 1'b0;
  endtask

  // Frame-level model: exactly FRAME_W counted bits commit a write, anything else is an error.
  task automatic model_frame(input logic [15:0] bits, input int n);
    if (n == FRAME_W) begin
      model_count = (model_count + 1) % 256;
      last_addr   = bits[FRAME_W-1:DATA_W];
      last_data   = bits[DATA_W-1:0];
      exp_q.push_back('{a: last_addr, d: last_data, c: 8'(model_count)});
    end else begin
      exp_err++;
    end
  endtask

  // Sends n counted bits; optional extra bits collide with the cs_n fall / rise and must be dropped.
  task automatic send_frame(input logic [15:0] bits, input int n,
                            input bit col_start, input bit col_end);
    if (col_start) begin
      bus.sdi_in  = 1'b1;
      bus.sclk_in = 1'b1;
      bus.cs_n_in = 1'b0;
      hold(4);
      bus.sclk_in = 1'b0;
    end else begin
      bus.cs_n_in = 1'b0;
      hold(4);
    end
    for (int i = 0; i < n; i++) shift_bit(bits[n-1-i]);
    if (col_end) begin
      bus.sdi_in = 1'($urandom);
      hold(4);
      bus.sclk_in = 1'b1;
      bus.cs_n_in = 1'b1;
      rise_cyc = cyc;
      hold(4);
      bus.sclk_in = 1'b0;
      hold(4);
    end else begin
      hold(4);
      bus.cs_n_in = 1'b1;
      rise_cyc = cyc;
      hold(6);
    end
    model_frame(bits, n);
  endtask

  task automatic drain(input string tag);
    wr_t o, e;
    check({tag, "/writes"}, obs_q.size(), exp_q.size());
    check({tag, "/errs"}, err_seen, exp_err);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "/address"}, o.a, e.a);
      check({tag, "/data"}, o.d, e.d);
      check({tag, "/frame_count"}, o.c, e.c);
    end
    obs_q.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  initial begin
    logic [15:0] bits;
    int          base;

    bus.cs_n_in = 1'b1;
    bus.sclk_in = 1'b0;
    bus.sdi_in  = 1'b0;
    hold(3);
    check("reset/write_strobe", bus.write_strobe, 0);
    check("reset/address", bus.address, 0);
    check("reset/data", bus.data, 0);
    check("reset/frame_err", bus.frame_err, 0);
    check("reset/frame_count", bus.frame_count, 0);
    rst = 1'b0;
    hold(8);
    drain("idle");

    // Valid frame to VOL_A, with strobe latency measured from the cs_n pin rise.
    send_frame(16'b010_01101, 8, 0, 0);
    check("valid/latency", strobe_cyc - rise_cyc, 3);
    check("valid/addr_is_vol_a", bus.address, VOL_A);
    drain("valid");

    // Short frame: error pulse, bus values held.
    bits = 16'($urandom);
    send_frame(bits, 7, 0, 0);
    drain("short");
    check("short/address_held", bus.address, last_addr);
    check("short/data_held", bus.data, last_data);

    // Long frame then a valid write to ENABLES.
    bits = 16'($urandom);
    send_frame(bits, 9, 0, 0);
    drain("long");
    send_frame(16'b101_00111, 8, 0, 0);
    check("after_long/addr_is_enables", bus.address, ENABLES);
    drain("after_long");

    // Random valid frames.
    for (int i = 0; i < 6; i++) begin
      bits = 16'($urandom);
      send_frame(bits, 8, 0, 0);
    end
    drain("random");

    // Reset mid-frame: abort silently, cs_n still low at release is not a new frame.
    bus.cs_n_in = 1'b0;
    hold(4);
    for (int i = 0; i < 4; i++) shift_bit(1'($urandom));
    rst = 1'b1;
    model_count = 0;
    last_addr   = '0;
    last_data   = '0;
    hold(3);
    check("midreset/frame_count", bus.frame_count, 0);
    check("midreset/address", bus.address, 0);
    rst = 1'b0;
    hold(4);
    for (int i = 0; i < 4; i++) shift_bit(1'($urandom));
    hold(4);
    bus.cs_n_in = 1'b1;
    hold(8);
    drain("midreset");

    // 256 back-to-back writes to PERIOD_A; first one is the post-reset recovery frame.
    base = strobe_total;
    for (int i = 0; i < 256; i++) begin
      bits = 16'({PERIOD_A, 5'(i % 32)});
      send_frame(bits, 8, 0, 0);
      drain("b2b");
    end
    check("b2b/strobes", strobe_total - base, 256);
    check("b2b/last_data", bus.data, 31);
    check("b2b/count_wrap", bus.frame_count, 0);

    // Collisions: sclk rise with cs_n fall and with cs_n rise are both discarded.
    bits = 16'($urandom);
    send_frame(bits, 8, 1, 1);
    check("collide/latency", strobe_cyc - rise_cyc, 3);
    drain("collide");

    check("strobe_err_exclusive", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
